cic_interpolator: RTL
=====================

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, bit width of each signed input sample (I and Q).
REQ-002 SHALL have parameter STAGES, default 3, number of comb stages and number of integrator stages (N); legal range 1..6.
REQ-003 SHALL have parameter RATE, default 8, interpolation factor (R); power of two, legal range 2..64.
REQ-004 SHALL have parameter DELAY, default 1, differential delay of each comb (M); legal values 1 or 2.
REQ-005 SHALL have derived localparam OUT_WIDTH = IN_WIDTH + STAGES*clog2(RATE*DELAY) - clog2(RATE), the width of the full-precision output.
REQ-006 SHALL have port i_clock, input, 1, single clock for all logic.
REQ-007 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_inph_data, input, IN_WIDTH, signed in-phase sample.
REQ-009 SHALL have port i_quad_data, input, IN_WIDTH, signed quadrature sample.
REQ-010 SHALL have port i_valid, input, 1, input sample present.
REQ-011 SHALL have port o_ready, output, 1, block can accept an input sample this cycle.
REQ-012 SHALL have port o_inph_data, output, OUT_WIDTH, signed interpolated in-phase sample.
REQ-013 SHALL have port o_quad_data, output, OUT_WIDTH, signed interpolated quadrature sample.
REQ-014 SHALL have port o_valid, output, 1, output sample valid (single-cycle qualifier, no backpressure).

Function
REQ-015 SHALL accept a sample on a rising edge where i_valid and o_ready are both high; the I and Q paths SHALL be identical and run in lockstep.
REQ-016 SHALL sign-extend inputs to OUT_WIDTH; all comb and integrator arithmetic SHALL be OUT_WIDTH two's complement with modular wrap and no saturation.
REQ-017 Comb section, per accepted sample only: y_k = x_k - x_k delayed by DELAY accepted samples, N stages cascaded combinationally; the result SHALL be registered into comb_reg at the accept edge, and each stage's delay line SHALL advance only on accept.
REQ-018 SHALL hold internal state have_sample (1 bit) and phase counter cnt (0..RATE-1).
REQ-019 o_ready SHALL be combinational: high when have_sample==0 or cnt==RATE-1.
REQ-020 On accept: comb_reg updated, have_sample<=1, cnt<=0.
REQ-021 Tick = any cycle with have_sample==1; on each tick the integrator chain SHALL update once with input comb_reg when cnt==0, else zero (zero-stuffing), N integrators cascaded combinationally within the cycle; cnt SHALL increment.
REQ-022 On the tick with cnt==RATE-1 and no simultaneous accept, have_sample SHALL clear; with a simultaneous accept, REQ-020 wins and the output stream is gapless.
REQ-023 o_valid SHALL be the tick registered by one cycle; o_inph_data/o_quad_data SHALL be the final integrator registers, updated only on ticks.
REQ-024 Latency: a sample accepted at edge E0 SHALL produce its first output with o_valid high in the cycle after edge E1, followed by RATE-1 further outputs on consecutive cycles.
REQ-025 Underrun (no accept when the run ends): integrators and outputs SHALL hold, o_valid SHALL be low, and no zeros SHALL be inserted; the stream resumes seamlessly on the next accept.
REQ-026 Per input sample, DC gain SHALL equal (RATE*DELAY)^STAGES / RATE at every output.

Reset
REQ-027 Asserting i_reset SHALL immediately and asynchronously clear all comb delay lines, comb_reg, integrators, cnt, have_sample, o_valid, o_inph_data and o_quad_data to 0; o_ready SHALL be 1 while in reset and after it.
REQ-028 A reset mid-run SHALL discard the remaining phases of the current sample; the first sample accepted after release SHALL behave as the first sample after power-up.

Verification (STAGES=3, RATE=4, DELAY=1, OUT_WIDTH=20)
REQ-029 Impulse: I=1 then zeros, offered continuously -> o_inph_data sequence 1,3,6,10,12,12,10,6,3,1 then 0; Q all 0.
REQ-030 DC: I=100, Q=-50 held continuously -> after 10 outputs, steady I=1600 and Q=-800 with o_valid continuously high.
REQ-031 Handshake: i_valid held high -> o_ready high exactly one cycle in every 4 and accepts spaced 4 cycles; first o_valid arrives 2 cycles after the first accept cycle.
REQ-032 Underrun: impulse with a 6-cycle input gap after sample 1 -> outputs match REQ-029 with o_valid low during the gap and no value changes.
REQ-033 Full scale: I=-32768 held -> steady output -524288 with no overflow; I=+32767 -> 524272.
REQ-034 Reset mid-run: i_reset pulsed asynchronously between edges during output 3 -> outputs immediately 0, o_valid 0, o_ready 1; a following impulse reproduces REQ-029 exactly.

Source files
------------

// File: rtl/cic_interpolator.sv
// CIC interpolator for an I/Q pair: comb section at the input rate, zero-stuffing,
// integrator section at the output rate, full-precision two's complement throughout.
module cic_interpolator #(
  parameter int IN_WIDTH = 16,
  parameter int STAGES   = 3,
  parameter int RATE     = 8,
  parameter int DELAY    = 1,
  localparam int OUT_WIDTH = IN_WIDTH + STAGES * $clog2(RATE * DELAY) - $clog2(RATE)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic signed [IN_WIDTH-1:0]  i_inph_data,
  input  logic signed [IN_WIDTH-1:0]  i_quad_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [OUT_WIDTH-1:0] o_inph_data,
  output logic signed [OUT_WIDTH-1:0] o_quad_data,
  output logic                        o_valid
);

  localparam int CW = $clog2(RATE);

  logic signed [OUT_WIDTH-1:0] dly_i [STAGES][DELAY];
  logic signed [OUT_WIDTH-1:0] dly_q [STAGES][DELAY];
  logic signed [OUT_WIDTH-1:0] comb_i [STAGES+1];
  logic signed [OUT_WIDTH-1:0] comb_q [STAGES+1];
  logic signed [OUT_WIDTH-1:0] comb_reg_i, comb_reg_q;
  logic signed [OUT_WIDTH-1:0] stuff_i, stuff_q;
  logic signed [OUT_WIDTH-1:0] integ_i [STAGES];
  logic signed [OUT_WIDTH-1:0] integ_q [STAGES];
  logic signed [OUT_WIDTH-1:0] nxt_i [STAGES];
  logic signed [OUT_WIDTH-1:0] nxt_q [STAGES];
  logic [CW-1:0] cnt;
  logic          have_sample;
  logic          last_phase;
  logic          accept;

  assign last_phase = (cnt == CW'(RATE - 1));
  assign o_ready    = !have_sample || last_phase;
  assign accept     = i_valid && o_ready;

  always_comb begin
    comb_i[0] = OUT_WIDTH'(i_inph_data);
    comb_q[0] = OUT_WIDTH'(i_quad_data);
    for (int s = 0; s < STAGES; s++) begin
      comb_i[s+1] = comb_i[s] - dly_i[s][DELAY-1];
      comb_q[s+1] = comb_q[s] - dly_q[s][DELAY-1];
    end
  end

  // Only phase 0 of each input sample feeds the integrators; other phases are zero-stuffed.
  always_comb begin
    stuff_i  = (cnt == '0) ? comb_reg_i : '0;
    stuff_q  = (cnt == '0) ? comb_reg_q : '0;
    nxt_i[0] = integ_i[0] + stuff_i;
    nxt_q[0] = integ_q[0] + stuff_q;
    for (int s = 1; s < STAGES; s++) begin
      nxt_i[s] = integ_i[s] + nxt_i[s-1];
      nxt_q[s] = integ_q[s] + nxt_q[s-1];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int d = 0; d < DELAY; d++) begin
          dly_i[s][d] <= '0;
          dly_q[s][d] <= '0;
        end
        integ_i[s] <= '0;
        integ_q[s] <= '0;
      end
      comb_reg_i  <= '0;
      comb_reg_q  <= '0;
      cnt         <= '0;
      have_sample <= 1'b0;
      o_valid     <= 1'b0;
    end else begin
      o_valid <= have_sample;
      if (accept) begin
        for (int s = 0; s < STAGES; s++) begin
          for (int d = DELAY - 1; d > 0; d--) begin
            dly_i[s][d] <= dly_i[s][d-1];
            dly_q[s][d] <= dly_q[s][d-1];
          end
          dly_i[s][0] <= comb_i[s];
          dly_q[s][0] <= comb_q[s];
        end
        comb_reg_i  <= comb_i[STAGES];
        comb_reg_q  <= comb_q[STAGES];
        have_sample <= 1'b1;
        cnt         <= '0;
      end else if (have_sample) begin
        cnt <= cnt + 1'b1;
        if (last_phase) have_sample <= 1'b0;
      end
      if (have_sample) begin
        for (int s = 0; s < STAGES; s++) begin
          integ_i[s] <= nxt_i[s];
          integ_q[s] <= nxt_q[s];
        end
      end
    end
  end

  assign o_inph_data = integ_i[STAGES-1];
  assign o_quad_data = integ_q[STAGES-1];

endmodule
